// File: rtl/alsu_pkg.sv
// Shared opcode definitions and invalid-request detection for the ALSU pipeline.
package alsu_pkg;

    // Opcode encodings as plain constants for use in expressions.
    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    // Enumerated view of the opcode field; codes 6 and 7 are reserved and always invalid.
    typedef enum logic [2:0] {
        OPC_OR    = 3'd0,
        OPC_XOR   = 3'd1,
        OPC_ADD   = 3'd2,
        OPC_MUL   = 3'd3,
        OPC_SHIFT = 3'd4,
        OPC_ROT   = 3'd5,
        OPC_RSV6  = 3'd6,
        OPC_RSV7  = 3'd7
    } alsu_op_e;

    // A request is invalid when a reduction is asked of any non-logic opcode,
    // or when a reserved opcode is used.
    function automatic logic alsu_invalid(
        input logic       redA,
        input logic       redB,
        input logic [2:0] op
    );
        return ((redA | redB) & (op[2] | op[1])) | (op == 3'd6) | (op == 3'd7);
    endfunction

endpackage

// File: rtl/alsu_pipe_core.sv
// Combinational result generator: turns the captured request fields and the
// current output value into the next output value and its invalid flag.
module alsu_pipe_core
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_cin,
    input  logic               i_serial,
    input  logic               i_redA,
    input  logic               i_redB,
    input  logic [2:0]         i_op,
    input  logic               i_bypA,
    input  logic               i_bypB,
    input  logic               i_dir,
    input  logic [2*WIDTH-1:0] i_out,
    output logic [2*WIDTH-1:0] o_next,
    output logic               o_inv
);

    localparam int OUT_W  = 2 * WIDTH;
    localparam bit PRIO_B = (INPUT_PRIORITY == "B");
    localparam bit FA_ON  = (FULL_ADDER == "ON");

    logic [OUT_W-1:0] w_sextA;
    logic [OUT_W-1:0] w_sextB;
    logic [OUT_W-1:0] w_cinExt;
    logic [OUT_W-1:0] w_sum;
    logic [OUT_W-1:0] w_prod;
    logic [WIDTH-1:0] w_redSel;
    logic             w_redAny;
    logic [OUT_W-1:0] w_redOr;
    logic [OUT_W-1:0] w_redXor;
    alsu_op_e         w_opE;

    // Both operands widened with their sign so every arithmetic and logic path
    // works directly in the full result width.
    assign w_sextA  = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sextB  = {{WIDTH{i_b[WIDTH-1]}}, i_b};

    // Carry-in only participates when the adder is built as a full adder.
    assign w_cinExt = {{(OUT_W-1){1'b0}}, (FA_ON & i_cin)};
    assign w_sum    = w_sextA + w_sextB + w_cinExt;

    // The low OUT_W bits of the product of two sign-extended operands equal the
    // exact signed product, which always fits in 2*WIDTH bits.
    assign w_prod   = w_sextA * w_sextB;

    assign w_redAny = i_redA | i_redB;
    assign w_redOr  = {{(OUT_W-1){1'b0}}, (|w_redSel)};
    assign w_redXor = {{(OUT_W-1){1'b0}}, (^w_redSel)};
    assign w_opE    = alsu_op_e'(i_op);

    // Pick which operand a reduction works on; the priority parameter breaks ties.
    always_comb begin
        w_redSel = i_a;
        if (i_redA && i_redB) begin
            w_redSel = PRIO_B ? i_b : i_a;
        end else if (i_redB) begin
            w_redSel = i_b;
        end
    end

    // Result selection: bypass beats the invalid check, which beats the opcode result.
    always_comb begin
        o_inv  = alsu_invalid(i_redA, i_redB, i_op);
        o_next = '0;
        if (i_bypA && i_bypB) begin
            o_next = PRIO_B ? w_sextB : w_sextA;
        end else if (i_bypA) begin
            o_next = w_sextA;
        end else if (i_bypB) begin
            o_next = w_sextB;
        end else if (o_inv) begin
            o_next = '0;
        end else begin
            case (w_opE)
                OPC_OR:    o_next = w_redAny ? w_redOr  : (w_sextA | w_sextB);
                OPC_XOR:   o_next = w_redAny ? w_redXor : (w_sextA ^ w_sextB);
                OPC_ADD:   o_next = w_sum;
                OPC_MUL:   o_next = w_prod;
                OPC_SHIFT: o_next = i_dir ? {i_out[OUT_W-2:0], i_serial}
                                          : {i_serial, i_out[OUT_W-1:1]};
                OPC_ROT:   o_next = i_dir ? {i_out[OUT_W-2:0], i_out[OUT_W-1]}
                                          : {i_out[0], i_out[OUT_W-1:1]};
                default:   o_next = '0;
            endcase
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage pipelined arithmetic/logic/shift unit with valid handshake,
// LED blink signalling of invalid requests and a saturating error counter.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic [2:0]           opcode,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic                 direction,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out,
    output logic                 invalid_op,
    output logic [LED_W-1:0]     leds,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int OUT_W = 2 * WIDTH;

    logic             r_v1;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_serial;
    logic             r_redA;
    logic             r_redB;
    logic [2:0]       r_op;
    logic             r_bypA;
    logic             r_bypB;
    logic             r_dir;

    logic [OUT_W-1:0] w_next;
    logic             w_inv;

    // Stage 1: capture the request when it is valid; fields hold otherwise so
    // the core never sees live inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_serial <= 1'b0;
            r_redA   <= 1'b0;
            r_redB   <= 1'b0;
            r_op     <= '0;
            r_bypA   <= 1'b0;
            r_bypB   <= 1'b0;
            r_dir    <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a      <= A;
                r_b      <= B;
                r_cin    <= cin;
                r_serial <= serial_in;
                r_redA   <= red_op_A;
                r_redB   <= red_op_B;
                r_op     <= opcode;
                r_bypA   <= bypass_A;
                r_bypB   <= bypass_B;
                r_dir    <= direction;
            end
        end
    end

    alsu_pipe_core #(
        .WIDTH          (WIDTH),
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_cin    (r_cin),
        .i_serial (r_serial),
        .i_redA   (r_redA),
        .i_redB   (r_redB),
        .i_op     (r_op),
        .i_bypA   (r_bypA),
        .i_bypB   (r_bypB),
        .i_dir    (r_dir),
        .i_out    (out),
        .o_next   (w_next),
        .o_inv    (w_inv)
    );

    // Stage 2: publish the result and its invalid flag; out is held between
    // requests because shift and rotate build on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out        <= '0;
            invalid_op <= 1'b0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                out        <= w_next;
                invalid_op <= w_inv;
            end
        end
    end

    // LEDs toggle on every invalid request and clear on any valid one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds <= '0;
        end else if (r_v1) begin
            leds <= w_inv ? ~leds : '0;
        end
    end

    // Count invalid requests, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (r_v1 && w_inv && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// Bench for alsu_pipe: two instances (priority A / full adder, priority B /
// half adder) compared every cycle against a queue-based request model, plus
// directed cases with hand-computed literal results.
module tb_alsu_pipe;

    localparam int WIDTH = 3;
    localparam int OUT_W = 6;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       ser;
        logic       redA;
        logic       redB;
        logic [2:0] op;
        logic       bypA;
        logic       bypB;
        logic       dir;
        int         due;
    } req_t;

    typedef struct {
        logic [5:0]  o;
        logic [5:0]  oAlt;
        logic        inv;
        logic [15:0] leds;
        logic [7:0]  err;
    } seen_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  A = '0;
    logic [2:0]  B = '0;
    logic        cin = 1'b0;
    logic        serial_in = 1'b0;
    logic        red_op_A = 1'b0;
    logic        red_op_B = 1'b0;
    logic [2:0]  opcode = '0;
    logic        bypass_A = 1'b0;
    logic        bypass_B = 1'b0;
    logic        direction = 1'b0;

    logic        outValid;
    logic [5:0]  out;
    logic        invalidOp;
    logic [15:0] leds;
    logic [7:0]  errCnt;
    logic        outValidAlt;
    logic [5:0]  outAlt;
    logic        invalidOpAlt;
    logic [15:0] ledsAlt;
    logic [7:0]  errCntAlt;

    int checks = 0;
    int passes = 0;
    bit checkEn = 1'b0;

    req_t  pend[$];
    seen_t seenOut[$];
    int          cycle = 0;
    logic        expValid = 1'b0;
    logic [5:0]  expOut = '0;
    logic [5:0]  expOutAlt = '0;
    logic        expInv = 1'b0;
    logic [15:0] expLeds = '0;
    int          expErr = 0;

    alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(outValid), .out(out),
        .invalid_op(invalidOp), .leds(leds), .err_cnt(errCnt)
    );

    alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dutAlt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(outValidAlt), .out(outAlt),
        .invalid_op(invalidOpAlt), .leds(ledsAlt), .err_cnt(errCntAlt)
    );

    always #5 clk = ~clk;

    function automatic int toSigned(input logic [2:0] v);
        return v[2] ? int'(v) - 8 : int'(v);
    endfunction

    function automatic logic isInvalid(input req_t r);
        return ((r.redA || r.redB) && r.op >= 3'd2) || r.op >= 3'd6;
    endfunction

    // Expected next output from the operation rules, for a given tie-break and adder choice.
    function automatic logic [5:0] modelResult(input req_t r, input logic [5:0] prev,
                                               input bit prioB, input bit faOn);
        int sa = toSigned(r.a);
        int sb = toSigned(r.b);
        int p  = int'(prev);
        int v  = 0;
        logic [2:0] sel;
        if (r.bypA && r.bypB)      v = prioB ? sb : sa;
        else if (r.bypA)           v = sa;
        else if (r.bypB)           v = sb;
        else if (isInvalid(r))     v = 0;
        else begin
            sel = (r.redA && r.redB) ? (prioB ? r.b : r.a) : (r.redA ? r.a : r.b);
            case (r.op)
                3'd0: v = (r.redA || r.redB) ? int'(sel != 3'd0) : (sa | sb);
                3'd1: v = (r.redA || r.redB) ? ($countones(sel) % 2) : (sa ^ sb);
                3'd2: v = sa + sb + ((faOn && r.cin) ? 1 : 0);
                3'd3: v = sa * sb;
                3'd4: v = r.dir ? ((p * 2) + int'(r.ser)) : ((int'(r.ser) * 32) + (p / 2));
                3'd5: v = r.dir ? ((p * 2) % 64 + (p / 32)) : ((p % 2) * 32 + (p / 2));
                default: v = 0;
            endcase
        end
        return 6'(v);
    endfunction

    // Reference model: requests queue up with a due cycle one edge after capture.
    initial begin
        req_t r;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pend.delete();
                cycle = 0;
                expValid = 1'b0;
                expOut = '0;
                expOutAlt = '0;
                expInv = 1'b0;
                expLeds = '0;
                expErr = 0;
            end else begin
                cycle++;
                expValid = 1'b0;
                if (pend.size() > 0 && pend[0].due == cycle) begin
                    r = pend.pop_front();
                    expValid  = 1'b1;
                    expOut    = modelResult(r, expOut, 1'b0, 1'b1);
                    expOutAlt = modelResult(r, expOutAlt, 1'b1, 1'b0);
                    expInv    = isInvalid(r);
                    expLeds   = expInv ? ~expLeds : 16'h0000;
                    if (expInv && expErr < 255) expErr++;
                end
                if (in_valid) begin
                    r.a = A; r.b = B; r.cin = cin; r.ser = serial_in;
                    r.redA = red_op_A; r.redB = red_op_B; r.op = opcode;
                    r.bypA = bypass_A; r.bypB = bypass_B; r.dir = direction;
                    r.due = cycle + 1;
                    pend.push_back(r);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Compare both instances against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (checkEn && !rst) begin
            checkOutput("out_valid", 32'(outValid), 32'(expValid));
            checkOutput("out", 32'(out), 32'(expOut));
            checkOutput("invalid_op", 32'(invalidOp), 32'(expInv));
            checkOutput("leds", 32'(leds), 32'(expLeds));
            checkOutput("err_cnt", 32'(errCnt), 32'(expErr));
            checkOutput("alt_out_valid", 32'(outValidAlt), 32'(expValid));
            checkOutput("alt_out", 32'(outAlt), 32'(expOutAlt));
        end
    end

    // Log every published result so directed cases can check literal sequences.
    always @(negedge clk) begin
        if (outValid) seenOut.push_back('{out, outAlt, invalidOp, leds, errCnt});
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input req_t r);
        @(negedge clk);
        in_valid = 1'b1;
        A = r.a; B = r.b; cin = r.cin; serial_in = r.ser;
        red_op_A = r.redA; red_op_B = r.redB; opcode = r.op;
        bypass_A = r.bypA; bypass_B = r.bypB; direction = r.dir;
    endtask

    function automatic req_t mkReq(input logic [2:0] a, input logic [2:0] b,
                                   input logic [2:0] op);
        req_t r;
        r.a = a; r.b = b; r.op = op; r.cin = 1'b0; r.ser = 1'b0;
        r.redA = 1'b0; r.redB = 1'b0; r.bypA = 1'b0; r.bypB = 1'b0;
        r.dir = 1'b0; r.due = 0;
        return r;
    endfunction

    task automatic checkSeen(input string name, input int idx, input logic [5:0] o,
                             input logic [5:0] oAlt);
        if (seenOut.size() > idx) begin
            checkOutput({name, "_out"}, 32'(seenOut[idx].o), 32'(o));
            checkOutput({name, "_alt"}, 32'(seenOut[idx].oAlt), 32'(oAlt));
        end else begin
            checkOutput({name, "_present"}, 32'(seenOut.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        req_t r;
        idle(2);
        rst = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_out", 32'(out), 32'h0);
        checkOutput("reset_leds", 32'(leds), 32'h0);
        checkOutput("reset_err", 32'(errCnt), 32'h0);

        // Add with carry: 3 + (-2) + 1 = 2; half-adder instance ignores cin -> 1.
        seenOut.delete();
        r = mkReq(3'd3, 3'b110, 3'd2); r.cin = 1'b1;
        applyStimulus(r);
        idle(4);
        checkOutput("add_count", 32'(seenOut.size()), 32'd1);
        checkSeen("add", 0, 6'd2, 6'd1);

        // Signed multiply: (-4)*(-4) = 16, 3*(-4) = -12.
        seenOut.delete();
        applyStimulus(mkReq(3'b100, 3'b100, 3'd3));
        idle(3);
        applyStimulus(mkReq(3'd3, 3'b100, 3'd3));
        idle(3);
        checkSeen("mul_pos", 0, 6'd16, 6'd16);
        checkSeen("mul_neg", 1, 6'b110100, 6'b110100);

        // Clear out, then three left shifts of 1 back-to-back and a right rotate.
        applyStimulus(mkReq(3'd0, 3'd0, 3'd0));
        idle(3);
        seenOut.delete();
        r = mkReq(3'd0, 3'd0, 3'd4); r.dir = 1'b1; r.ser = 1'b1;
        applyStimulus(r);
        applyStimulus(r);
        applyStimulus(r);
        r = mkReq(3'd0, 3'd0, 3'd5); r.dir = 1'b0;
        applyStimulus(r);
        idle(3);
        checkSeen("shift1", 0, 6'd1, 6'd1);
        checkSeen("shift2", 1, 6'd3, 6'd3);
        checkSeen("shift3", 2, 6'd7, 6'd7);
        checkSeen("rotate", 3, 6'b100011, 6'b100011);

        // Invalid requests toggle LEDs and count; a valid one clears LEDs.
        seenOut.delete();
        r = mkReq(3'd1, 3'd2, 3'd2); r.redA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(r);
            idle(3);
        end
        applyStimulus(mkReq(3'd1, 3'd2, 3'd0));
        idle(3);
        if (seenOut.size() == 4) begin
            checkOutput("inv1_out", 32'(seenOut[0].o), 32'h0);
            checkOutput("inv1_flag", 32'(seenOut[0].inv), 32'h1);
            checkOutput("inv1_leds", 32'(seenOut[0].leds), 32'hFFFF);
            checkOutput("inv1_err", 32'(seenOut[0].err), 32'd1);
            checkOutput("inv2_leds", 32'(seenOut[1].leds), 32'h0000);
            checkOutput("inv2_err", 32'(seenOut[1].err), 32'd2);
            checkOutput("inv3_leds", 32'(seenOut[2].leds), 32'hFFFF);
            checkOutput("valid_leds", 32'(seenOut[3].leds), 32'h0000);
            checkOutput("valid_flag", 32'(seenOut[3].inv), 32'h0);
            checkOutput("valid_out", 32'(seenOut[3].o), 32'd3);
        end else begin
            checkOutput("inv_count", 32'(seenOut.size()), 32'd4);
        end

        // Both bypass flags: priority A gives -1, priority B gives 2.
        seenOut.delete();
        r = mkReq(3'b111, 3'd2, 3'd6); r.bypA = 1'b1; r.bypB = 1'b1;
        applyStimulus(r);
        idle(3);
        checkSeen("bypass", 0, 6'b111111, 6'd2);

        // Reset one cycle after a request: nothing may emerge and all outputs clear.
        applyStimulus(mkReq(3'd3, 3'd3, 3'd2));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seenOut.delete();
        idle(4);
        checkOutput("rst_no_valid", 32'(seenOut.size()), 32'd0);
        checkOutput("rst_out", 32'(out), 32'h0);
        checkOutput("rst_leds", 32'(leds), 32'h0);
        checkOutput("rst_err", 32'(errCnt), 32'h0);
        checkOutput("rst_inv", 32'(invalidOp), 32'h0);

        // Random traffic, with reduction and bypass flags kept fairly rare.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 3'($urandom);
            B         = 3'($urandom);
            cin       = 1'($urandom);
            serial_in = 1'($urandom);
            red_op_A  = ($urandom_range(0, 7) == 0);
            red_op_B  = ($urandom_range(0, 7) == 0);
            opcode    = 3'($urandom);
            bypass_A  = ($urandom_range(0, 7) == 0);
            bypass_B  = ($urandom_range(0, 7) == 0);
            direction = 1'($urandom);
        end
        idle(3);

        // Drive 300 invalid requests; the counter must stick at 255.
        r = mkReq(3'd0, 3'd0, 3'd7);
        for (int i = 0; i < 300; i++) applyStimulus(r);
        idle(3);
        checkOutput("err_saturate", 32'(errCnt), 32'd255);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
Parametrised next-generation arithmetic/logic/shift unit. It generalises the 3-bit ALSU to WIDTH-bit signed operands and a 2*WIDTH result. It adds a valid handshake through a two-stage pipeline, a selectable carry-in, and a saturating error counter. It sits in the datapath between operand sources and a result consumer, and drives the board LEDs for invalid-operation signalling.

Parameters:
WIDTH, 3, operand width in bits (signed); legal range 2..16
OUT_W, 2*WIDTH, result width (derived localparam, not overridable)
INPUT_PRIORITY, "A", operand chosen when both bypass or both reduction flags are set ("A" or "B")
FULL_ADDER, "ON", "ON" adds cin in opcode 2; "OFF" ignores cin
LED_W, 16, LED bus width
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/control inputs are valid this cycle
A  in  WIDTH  signed operand A
B  in  WIDTH  signed operand B
cin  in  1  carry-in
serial_in  in  1  shift-in bit
red_op_A  in  1  reduction on A
red_op_B  in  1  reduction on B
opcode  in  3  operation select
bypass_A  in  1  pass A through
bypass_B  in  1  pass B through
direction  in  1  1 = left, 0 = right
out_valid  out  1  out holds a new result this cycle
out  out  OUT_W  signed result
invalid_op  out  1  the result currently flagged by out_valid came from an invalid request
leds  out  LED_W  blink pattern
err_cnt  out  ERR_CNT_W  saturating count of invalid requests

Behaviour:
- Reset: all stage-1 registers, v1, out, out_valid, invalid_op, leds and err_cnt are 0. Reset applied mid-operation discards any in-flight request; no out_valid follows it.
- Stage 1: when in_valid=1, capture all inputs into the stage-1 registers and set v1<=1. Otherwise v1<=0 and the captured fields hold.
- Stage 2: acts only when v1=1. Sets out_valid<=v1, so the latency from in_valid to out_valid is exactly 2 cycles. The unit accepts one request per cycle and has no backpressure.
- Invalid detection (on the stage-1 registers): inv = ((red_A|red_B) & (op[2]|op[1])) | (op==6) | (op==7). This must use the registered opcode, never the live input.
- Result priority when v1=1:
  - both bypass flags set: INPUT_PRIORITY operand
  - only bypass_A: A
  - only bypass_B: B
  - inv: 0
  - otherwise, the opcode result
- Bypass takes precedence over inv, but invalid_op<=inv regardless of bypass.
- Opcode results:
  - 0: OR. With a reduction flag, the result is the reduction OR of the selected operand (INPUT_PRIORITY when both flags are set), zero-extended. Otherwise sign-extended A|B.
  - 1: XOR, with the same reduction rules as opcode 0.
  - 2: sext(A)+sext(B)(+cin if FULL_ADDER=="ON"), computed in OUT_W bits.
  - 3: signed A*B in OUT_W bits; the result never overflows.
  - 4: shift. direction=1 gives {out[OUT_W-2:0],serial_in}; direction=0 gives {serial_in,out[OUT_W-1:1]}.
  - 5: rotate of out. Left is {out[OUT_W-2:0],out[OUT_W-1]}; right is {out[0],out[OUT_W-1:1]}.
- Opcodes 4 and 5 operate on the previous out value, which is held across idle cycles.
- Operand sign-extension: bypassed operands and non-reduced opcode 0/1 operands are sign-extended to OUT_W.
- When v1=0: out, invalid_op and leds hold; out_valid=0.
- LEDs: when v1 & inv, leds<=~leds. When v1 & !inv, leds<=0.
- err_cnt: increments on v1 & inv and saturates at all-ones (no wrap).

Decomposition:
- Package alsu_pkg holds:
  - opcode constants: OP_OR=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROT=5
  - an opcode enum typedef
  - the function that computes the invalid flag
- One combinational sub-module, alsu_pipe_core, computes the next result from the stage-1 fields and the current out. The pipeline registers, LEDs and counter remain in alsu_pipe.

Test Plan:
1. WIDTH=3, A=3, B=-2, cin=1, op=2, FULL_ADDER="ON", in_valid for 1 cycle -> 2 cycles later out_valid=1 for one cycle, out=2. With FULL_ADDER="OFF" -> out=1.
2. A=-4, B=-4, op=3 -> out=16. A=3, B=-4, op=3 -> out=-12 (6'b110100).
3. out=0; op=4, direction=1, serial_in=1 for 3 back-to-back requests -> out=1, 3, 7 on consecutive cycles. Then op=5, direction=0 -> out=6'b100011.
4. red_op_A=1, op=2 -> out=0, invalid_op=1, leds=16'hFFFF, err_cnt=1. A second invalid request -> leds=0x0000, err_cnt=2. A valid request -> leds=0.
5. bypass_A=bypass_B=1, A=-1, B=2, INPUT_PRIORITY="B" -> out=2. Same with INPUT_PRIORITY="A" -> out=-1 (6'b111111).
6. Assert rst one cycle after in_valid -> out_valid never rises and all outputs are 0. Separately, force 300 invalid requests -> err_cnt holds at 255.
